// File: rtl/pipe_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit_pkg
// Brief    : Opcodes, ALU encodings, control bundle and memory FSM states.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_unit_pkg;

    localparam int OPCODE_W = 7;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [1:0]          alu_op_t;
    typedef logic [1:0]          alu_src_t;

    localparam opcode_t OPCODE_ARITHM_REG = 7'b0110011;
    localparam opcode_t OPCODE_ARITHM_IMM = 7'b0010011;
    localparam opcode_t OPCODE_LOAD       = 7'b0000011;
    localparam opcode_t OPCODE_STORE      = 7'b0100011;
    localparam opcode_t OPCODE_BRANCH     = 7'b1100011;

    localparam alu_op_t ALU_OP_ARITHM_REG = 2'b00;
    localparam alu_op_t ALU_OP_ARITHM_IMM = 2'b01;

    localparam alu_src_t ALU_SRC_REG    = 2'b00;
    localparam alu_src_t ALU_SRC_IMM    = 2'b01;
    localparam alu_src_t ALU_SRC_STORE  = 2'b10;
    localparam alu_src_t ALU_SRC_BRANCH = 2'b11;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // An all-zero bundle is the pipeline bubble.
    typedef struct packed {
        alu_op_t  alu_op_mode;
        alu_src_t alu_src;
        logic     brn_cond;
        logic     mem_we;
        logic     mem_to_reg;
        logic     reg_we;
        logic     illegal;
        logic     valid;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit_if
// Brief    : D-stage inputs, pipeline controls, hazards and memory handshake.
// Revision : 1.0
// ============================================================================
interface pipe_ctrl_unit_if
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
);
    logic                  valid_d;
    opcode_t               opcode_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  branch_taken_e;
    logic                  mem_ready;

    alu_op_t               alu_op_mode_e;
    alu_src_t              alu_src_e;
    logic                  brn_cond_e;
    logic                  mem_we_e;
    logic                  mem_to_reg_e;
    logic                  reg_we_e;
    logic                  valid_e;
    logic                  illegal_e;
    logic [REG_ADDR_W-1:0] rd_e;

    logic                  mem_we_m;
    logic                  mem_to_reg_m;
    logic                  reg_we_m;
    logic                  valid_m;
    logic [REG_ADDR_W-1:0] rd_m;

    logic                  mem_req;
    logic                  stall_fd;
    logic                  stall_em;
    logic                  flush_d;
    logic                  mem_err;

    modport master (
        output valid_d, opcode_d, rd_d, rs1_d, rs2_d, branch_taken_e, mem_ready,
        input  alu_op_mode_e, alu_src_e, brn_cond_e, mem_we_e, mem_to_reg_e,
               reg_we_e, valid_e, illegal_e, rd_e,
               mem_we_m, mem_to_reg_m, reg_we_m, valid_m, rd_m,
               mem_req, stall_fd, stall_em, flush_d, mem_err
    );

    modport slave (
        input  valid_d, opcode_d, rd_d, rs1_d, rs2_d, branch_taken_e, mem_ready,
        output alu_op_mode_e, alu_src_e, brn_cond_e, mem_we_e, mem_to_reg_e,
               reg_we_e, valid_e, illegal_e, rd_e,
               mem_we_m, mem_to_reg_m, reg_we_m, valid_m, rd_m,
               mem_req, stall_fd, stall_em, flush_d, mem_err
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational D-stage opcode decoder producing the control bundle.
// Revision : 1.0
// ============================================================================
module ctrl_decode
    import pipe_ctrl_unit_pkg::*;
(
    input  wire logic    i_valid,
    input  wire opcode_t i_opcode,
    output ctrl_t        o_ctrl,
    output logic         o_rs2_used
);

    always_comb begin
        o_ctrl       = '0;
        o_rs2_used   = 1'b0;
        o_ctrl.valid = i_valid;
        case (i_opcode)
            OPCODE_ARITHM_REG: begin
                o_ctrl.alu_op_mode = ALU_OP_ARITHM_REG;
                o_ctrl.alu_src     = ALU_SRC_REG;
                o_ctrl.reg_we      = i_valid;
                o_rs2_used         = 1'b1;
            end
            OPCODE_ARITHM_IMM: begin
                o_ctrl.alu_op_mode = ALU_OP_ARITHM_IMM;
                o_ctrl.alu_src     = ALU_SRC_IMM;
                o_ctrl.reg_we      = i_valid;
            end
            OPCODE_LOAD: begin
                o_ctrl.alu_op_mode = ALU_OP_ARITHM_IMM;
                o_ctrl.alu_src     = ALU_SRC_IMM;
                o_ctrl.reg_we      = i_valid;
                o_ctrl.mem_to_reg  = i_valid;
            end
            OPCODE_STORE: begin
                o_ctrl.alu_op_mode = ALU_OP_ARITHM_IMM;
                o_ctrl.alu_src     = ALU_SRC_STORE;
                o_ctrl.mem_we      = i_valid;
                o_rs2_used         = 1'b1;
            end
            OPCODE_BRANCH: begin
                o_ctrl.alu_op_mode = ALU_OP_ARITHM_IMM;
                o_ctrl.alu_src     = ALU_SRC_BRANCH;
                o_ctrl.brn_cond    = i_valid;
                o_rs2_used         = 1'b1;
            end
            default: begin
                // A non-instruction slot is never flagged illegal.
                o_ctrl.alu_src = ALU_SRC_BRANCH;
                o_ctrl.illegal = i_valid;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Pipelined control (D->E->M) with hazard stall/flush and memory FSM.
// Revision : 1.0
// ============================================================================
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_ctrl_unit_if.slave   bus
);

    localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    ctrl_t                 w_ctrl_d;
    logic                  w_rs2_used_d;
    ctrl_t                 r_ctrl_e;
    logic [REG_ADDR_W-1:0] r_rd_e;
    logic                  r_mem_we_m;
    logic                  r_mem_to_reg_m;
    logic                  r_reg_we_m;
    logic                  r_valid_m;
    logic [REG_ADDR_W-1:0] r_rd_m;

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_mem_err;
    logic                  w_mem_req;
    logic                  w_ms;
    logic                  w_timeout;
    logic                  w_lu;

    ctrl_decode u_ctrl_decode (
        .i_valid    (bus.valid_d),
        .i_opcode   (bus.opcode_d),
        .o_ctrl     (w_ctrl_d),
        .o_rs2_used (w_rs2_used_d)
    );

    assign w_lu = r_ctrl_e.valid & r_ctrl_e.mem_to_reg & (r_rd_e != '0) & bus.valid_d &
                  ((r_rd_e == bus.rs1_d) | (w_rs2_used_d & (r_rd_e == bus.rs2_d)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_req   = 1'b0;
        w_ms        = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                w_mem_req = r_valid_m & (r_mem_we_m | r_mem_to_reg_m);
                if (w_mem_req && !bus.mem_ready) begin
                    w_ms        = 1'b1;
                    w_state_nxt = MEM_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            MEM_WAIT: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_state_nxt = MEM_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    // Abort: let the access retire so the pipeline cannot lock up.
                    w_timeout   = 1'b1;
                    w_state_nxt = MEM_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_ms      = 1'b1;
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= MEM_IDLE;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= r_mem_err | w_timeout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_e       <= '0;
            r_rd_e         <= '0;
            r_mem_we_m     <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_reg_we_m     <= 1'b0;
            r_valid_m      <= 1'b0;
            r_rd_m         <= '0;
        end else if (!w_ms) begin
            r_mem_we_m     <= r_ctrl_e.mem_we;
            r_mem_to_reg_m <= r_ctrl_e.mem_to_reg;
            r_reg_we_m     <= r_ctrl_e.reg_we;
            r_valid_m      <= r_ctrl_e.valid;
            r_rd_m         <= r_rd_e;
            if (bus.branch_taken_e || w_lu) begin
                r_ctrl_e <= '0;
                r_rd_e   <= '0;
            end else begin
                r_ctrl_e <= w_ctrl_d;
                r_rd_e   <= bus.rd_d;
            end
        end
    end

    assign bus.alu_op_mode_e = r_ctrl_e.alu_op_mode;
    assign bus.alu_src_e     = r_ctrl_e.alu_src;
    assign bus.brn_cond_e    = r_ctrl_e.brn_cond;
    assign bus.mem_we_e      = r_ctrl_e.mem_we;
    assign bus.mem_to_reg_e  = r_ctrl_e.mem_to_reg;
    assign bus.reg_we_e      = r_ctrl_e.reg_we;
    assign bus.valid_e       = r_ctrl_e.valid;
    assign bus.illegal_e     = r_ctrl_e.illegal;
    assign bus.rd_e          = r_rd_e;

    assign bus.mem_we_m      = r_mem_we_m;
    assign bus.mem_to_reg_m  = r_mem_to_reg_m;
    assign bus.reg_we_m      = r_reg_we_m & ~w_timeout;
    assign bus.valid_m       = r_valid_m;
    assign bus.rd_m          = r_rd_m;

    assign bus.mem_req       = w_mem_req;
    assign bus.stall_em      = w_ms;
    assign bus.stall_fd      = w_ms | (~bus.branch_taken_e & w_lu);
    assign bus.flush_d       = ~w_ms & bus.branch_taken_e;
    assign bus.mem_err       = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed and random stimulus against an instruction-level model.
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl_unit;
    import pipe_ctrl_unit_pkg::*;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 4;

    typedef struct {
        logic       valid;
        logic [6:0] op;
        logic [4:0] rd;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_errors = 0;

    instr_t m_e;
    instr_t m_m;
    int     m_wait;
    logic   m_err;

    logic [6:0] c_ops [5] = '{OPCODE_ARITHM_REG, OPCODE_ARITHM_IMM, OPCODE_LOAD,
                              OPCODE_STORE, OPCODE_BRANCH};

    pipe_ctrl_unit_if #(.REG_ADDR_W(REG_ADDR_W)) bus ();

    pipe_ctrl_unit #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OPCODE_ARITHM_REG) || (op == OPCODE_ARITHM_IMM) ||
               (op == OPCODE_LOAD) || (op == OPCODE_STORE) || (op == OPCODE_BRANCH);
    endfunction

    function automatic logic writes_reg(input logic [6:0] op);
        return (op == OPCODE_ARITHM_REG) || (op == OPCODE_ARITHM_IMM) || (op == OPCODE_LOAD);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OPCODE_ARITHM_REG) || (op == OPCODE_STORE) || (op == OPCODE_BRANCH);
    endfunction

    function automatic logic [1:0] exp_src(input logic [6:0] op);
        if (op == OPCODE_ARITHM_REG) return ALU_SRC_REG;
        if (op == OPCODE_ARITHM_IMM || op == OPCODE_LOAD) return ALU_SRC_IMM;
        if (op == OPCODE_STORE) return ALU_SRC_STORE;
        return ALU_SRC_BRANCH;
    endfunction

    task automatic model_reset();
        m_e    = '{1'b0, 7'd0, 5'd0};
        m_m    = '{1'b0, 7'd0, 5'd0};
        m_wait = 0;
        m_err  = 1'b0;
    endtask

    // One clock: drive D-stage inputs, check every output mid-cycle, advance the model.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic bt, input logic rdy);
        logic req, ms, tmo, lu;
        bus.valid_d        = v;
        bus.opcode_d       = op;
        bus.rd_d           = rd;
        bus.rs1_d          = rs1;
        bus.rs2_d          = rs2;
        bus.branch_taken_e = bt;
        bus.mem_ready      = rdy;
        req = m_m.valid && (m_m.op == OPCODE_LOAD || m_m.op == OPCODE_STORE);
        tmo = req && !rdy && (m_wait >= MEM_TIMEOUT);
        ms  = req && !rdy && (m_wait < MEM_TIMEOUT);
        lu  = v && m_e.valid && (m_e.op == OPCODE_LOAD) && (m_e.rd != 5'd0) &&
              ((m_e.rd == rs1) || (reads_rs2(op) && (m_e.rd == rs2)));
        @(negedge clk);
        check("mem_req", bus.mem_req, req);
        check("stall_em", bus.stall_em, ms);
        check("stall_fd", bus.stall_fd, ms || (!bt && lu));
        check("flush_d", bus.flush_d, !ms && bt);
        check("mem_err", bus.mem_err, m_err);
        check("valid_e", bus.valid_e, m_e.valid);
        check("reg_we_e", bus.reg_we_e, m_e.valid && writes_reg(m_e.op));
        check("mem_to_reg_e", bus.mem_to_reg_e, m_e.valid && (m_e.op == OPCODE_LOAD));
        check("mem_we_e", bus.mem_we_e, m_e.valid && (m_e.op == OPCODE_STORE));
        check("brn_cond_e", bus.brn_cond_e, m_e.valid && (m_e.op == OPCODE_BRANCH));
        check("illegal_e", bus.illegal_e, m_e.valid && !is_legal(m_e.op));
        if (m_e.valid) begin
            check("rd_e", bus.rd_e, m_e.rd);
            check("alu_src_e", bus.alu_src_e, exp_src(m_e.op));
            if (is_legal(m_e.op))
                check("alu_op_mode_e", bus.alu_op_mode_e,
                      (m_e.op == OPCODE_ARITHM_REG) ? ALU_OP_ARITHM_REG : ALU_OP_ARITHM_IMM);
        end
        check("valid_m", bus.valid_m, m_m.valid);
        check("mem_we_m", bus.mem_we_m, m_m.valid && (m_m.op == OPCODE_STORE));
        check("mem_to_reg_m", bus.mem_to_reg_m, m_m.valid && (m_m.op == OPCODE_LOAD));
        check("reg_we_m", bus.reg_we_m, m_m.valid && writes_reg(m_m.op) && !tmo);
        if (m_m.valid)
            check("rd_m", bus.rd_m, m_m.rd);
        @(posedge clk);
        if (ms) begin
            m_wait++;
        end else begin
            m_wait = 0;
            if (tmo) m_err = 1'b1;
            m_m = m_e;
            if (bt || lu) m_e = '{1'b0, 7'd0, 5'd0};
            else          m_e = '{v, op, rd};
        end
        #1;
    endtask

    task automatic nop(input logic rdy);
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, rdy);
    endtask

    task automatic apply_reset();
        bus.valid_d        = 1'b0;
        bus.opcode_d       = 7'd0;
        bus.rd_d           = 5'd0;
        bus.rs1_d          = 5'd0;
        bus.rs2_d          = 5'd0;
        bus.branch_taken_e = 1'b0;
        bus.mem_ready      = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_e_bundle", {bus.alu_op_mode_e, bus.alu_src_e, bus.brn_cond_e, bus.mem_we_e,
                               bus.mem_to_reg_e, bus.reg_we_e, bus.valid_e, bus.illegal_e,
                               bus.rd_e}, 32'd0);
        check("rst_m_bundle", {bus.mem_we_m, bus.mem_to_reg_m, bus.reg_we_m, bus.valid_m,
                               bus.rd_m}, 32'd0);
        check("rst_hazard", {bus.mem_req, bus.stall_fd, bus.stall_em, bus.flush_d}, 32'd0);
        check("rst_mem_err", bus.mem_err, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        int         rdy_pct;
        int         sel;

        model_reset();
        apply_reset();

        // Decode table stream, one cycle per instruction.
        step(1'b1, OPCODE_ARITHM_REG, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_ARITHM_IMM, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_LOAD,       5'd3, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_STORE,      5'd4, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_BRANCH,     5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, 7'h7F,             5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
        nop(1'b1);
        nop(1'b1);

        // Load-use on x5: ADD held in D for one extra cycle.
        step(1'b1, OPCODE_LOAD,       5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_ARITHM_REG, 5'd6, 5'd5, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_ARITHM_REG, 5'd6, 5'd5, 5'd0, 1'b0, 1'b1);
        nop(1'b1);

        // Load to x0 never creates a hazard.
        step(1'b1, OPCODE_LOAD,       5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_ARITHM_REG, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1);
        nop(1'b1);
        nop(1'b1);

        // Store waits three cycles for memory.
        step(1'b1, OPCODE_STORE, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
        nop(1'b1);
        nop(1'b0);
        nop(1'b0);
        nop(1'b0);
        nop(1'b1);
        nop(1'b1);

        // Memory never answers: timeout, sticky error, pipeline resumes.
        step(1'b1, OPCODE_LOAD, 5'd9, 5'd1, 5'd0, 1'b0, 1'b1);
        nop(1'b1);
        for (int i = 0; i < 6; i++) nop(1'b0);
        step(1'b1, OPCODE_ARITHM_IMM, 5'd8, 5'd1, 5'd0, 1'b0, 1'b1);
        nop(1'b1);
        nop(1'b1);

        // Branch flush beats load-use, then reset lands mid-WAIT.
        apply_reset();
        step(1'b1, OPCODE_LOAD,       5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OPCODE_ARITHM_REG, 5'd3, 5'd2, 5'd0, 1'b1, 1'b1);
        nop(1'b0);
        nop(1'b0);
        apply_reset();

        for (int blk = 0; blk < 4; blk++) begin
            rdy_pct = (blk % 2 == 0) ? 75 : 35;
            for (int i = 0; i < 150; i++) begin
                sel = $urandom_range(0, 5);
                if (sel < 5) op = c_ops[sel];
                else         op = 7'($urandom);
                step($urandom_range(0, 9) != 0, op,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 99) < rdy_pct);
            end
            apply_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
